// File: rtl/sauria_tile_pointer_sequencer.sv
// Walks a 4-D (x, y, c, k) tile space in a programmable loop order and emits per-tensor offsets.
// Optional tile_idx output is enabled by defining SAURIA_PTRGEN_TILE_COUNT_EN.
module sauria_tile_pointer_sequencer #(
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  x_lim,
  input  logic [CNT_W-1:0]  y_lim,
  input  logic [CNT_W-1:0]  c_lim,
  input  logic [CNT_W-1:0]  k_lim,
  input  logic [ADDR_W-1:0] ifm_x_step,
  input  logic [ADDR_W-1:0] ifm_y_step,
  input  logic [ADDR_W-1:0] ifm_c_step,
  input  logic [ADDR_W-1:0] ps_x_step,
  input  logic [ADDR_W-1:0] ps_y_step,
  input  logic [ADDR_W-1:0] ps_k_step,
  input  logic [ADDR_W-1:0] w_c_step,
  input  logic [ADDR_W-1:0] w_k_step,
  input  logic [1:0]        loop_order,
  output logic              ptr_valid,
  input  logic              ptr_ready,
  output logic [ADDR_W-1:0] ifmaps_offset,
  output logic [ADDR_W-1:0] psums_offset,
  output logic [ADDR_W-1:0] weights_offset,
  output logic              ifmaps_change,
  output logic              psums_change,
  output logic              weights_change,
  output logic              last_iter,
`ifdef SAURIA_PTRGEN_TILE_COUNT_EN
  output logic [31:0]       tile_idx,
`endif
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  xl, yl, cl, kl;
  logic [ADDR_W-1:0] s_ifm_x, s_ifm_y, s_ifm_c, s_ps_x, s_ps_y, s_ps_k, s_w_c, s_w_k;
  logic [1:0]        ord;
  logic [CNT_W-1:0]  x, y, c, k;
  logic [CNT_W-1:0]  x_n, y_n, c_n, k_n;
  logic [ADDR_W-1:0] ifm_x_cnt, ifm_y_cnt, ifm_c_cnt, ps_x_cnt, ps_y_cnt, ps_k_cnt, w_c_cnt, w_k_cnt;
  logic              xw, yw, cw, kw, xyw;
  logic              en_xy, en_c, en_k, step_x, step_y;

  assign ptr_valid      = (state == ST_RUN);
  assign busy           = (state != ST_IDLE);
  assign done           = (state == ST_DONE);
  assign ifmaps_offset  = ifm_x_cnt + ifm_y_cnt + ifm_c_cnt;
  assign psums_offset   = ps_x_cnt + ps_y_cnt + ps_k_cnt;
  assign weights_offset = w_c_cnt + w_k_cnt;

  assign xw  = (x == xl);
  assign yw  = (y == yl);
  assign cw  = (c == cl);
  assign kw  = (k == kl);
  assign xyw = xw & yw;
  assign last_iter = ptr_valid & xyw & cw & kw;

  // A group steps only when every group inside it has wrapped in the selected order.
  always_comb begin
    en_xy = 1'b0;
    en_c  = 1'b0;
    en_k  = 1'b0;
    case (ord)
      2'd0: begin en_xy = 1'b1; en_c = xyw; en_k = xyw & cw; end
      2'd1: begin en_c = 1'b1; en_k = cw; en_xy = cw & kw; end
      2'd2: begin en_k = 1'b1; en_c = kw; en_xy = kw & cw; end
      default: begin en_c = 1'b1; en_xy = cw; en_k = cw & xyw; end
    endcase
    step_x = en_xy;
    step_y = en_xy & xw;
    x_n = x;
    y_n = y;
    c_n = c;
    k_n = k;
    if (step_x) x_n = xw ? '0 : x + CNT_W'(1);
    if (step_y) y_n = yw ? '0 : y + CNT_W'(1);
    if (en_c)   c_n = cw ? '0 : c + CNT_W'(1);
    if (en_k)   k_n = kw ? '0 : k + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      xl <= '0; yl <= '0; cl <= '0; kl <= '0;
      s_ifm_x <= '0; s_ifm_y <= '0; s_ifm_c <= '0;
      s_ps_x <= '0; s_ps_y <= '0; s_ps_k <= '0;
      s_w_c <= '0; s_w_k <= '0;
      ord <= '0;
      x <= '0; y <= '0; c <= '0; k <= '0;
      ifm_x_cnt <= '0; ifm_y_cnt <= '0; ifm_c_cnt <= '0;
      ps_x_cnt <= '0; ps_y_cnt <= '0; ps_k_cnt <= '0;
      w_c_cnt <= '0; w_k_cnt <= '0;
      ifmaps_change <= 1'b1; psums_change <= 1'b1; weights_change <= 1'b1;
`ifdef SAURIA_PTRGEN_TILE_COUNT_EN
      tile_idx <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state <= ST_RUN;
          xl <= x_lim; yl <= y_lim; cl <= c_lim; kl <= k_lim;
          s_ifm_x <= ifm_x_step; s_ifm_y <= ifm_y_step; s_ifm_c <= ifm_c_step;
          s_ps_x <= ps_x_step; s_ps_y <= ps_y_step; s_ps_k <= ps_k_step;
          s_w_c <= w_c_step; s_w_k <= w_k_step;
          ord <= loop_order;
          x <= '0; y <= '0; c <= '0; k <= '0;
          ifm_x_cnt <= '0; ifm_y_cnt <= '0; ifm_c_cnt <= '0;
          ps_x_cnt <= '0; ps_y_cnt <= '0; ps_k_cnt <= '0;
          w_c_cnt <= '0; w_k_cnt <= '0;
          ifmaps_change <= 1'b1; psums_change <= 1'b1; weights_change <= 1'b1;
`ifdef SAURIA_PTRGEN_TILE_COUNT_EN
          tile_idx <= '0;
`endif
        end
        ST_RUN: if (ptr_ready) begin
`ifdef SAURIA_PTRGEN_TILE_COUNT_EN
          tile_idx <= tile_idx + 32'd1;
`endif
          if (last_iter) begin
            state <= ST_DONE;
          end else begin
            x <= x_n; y <= y_n; c <= c_n; k <= k_n;
            if (step_x) begin
              ifm_x_cnt <= xw ? '0 : ifm_x_cnt + s_ifm_x;
              ps_x_cnt  <= xw ? '0 : ps_x_cnt + s_ps_x;
            end
            if (step_y) begin
              ifm_y_cnt <= yw ? '0 : ifm_y_cnt + s_ifm_y;
              ps_y_cnt  <= yw ? '0 : ps_y_cnt + s_ps_y;
            end
            if (en_c) begin
              ifm_c_cnt <= cw ? '0 : ifm_c_cnt + s_ifm_c;
              w_c_cnt   <= cw ? '0 : w_c_cnt + s_w_c;
            end
            if (en_k) begin
              ps_k_cnt <= kw ? '0 : ps_k_cnt + s_ps_k;
              w_k_cnt  <= kw ? '0 : w_k_cnt + s_w_k;
            end
            ifmaps_change  <= (x_n != x) | (y_n != y) | (c_n != c);
            psums_change   <= (x_n != x) | (y_n != y) | (k_n != k);
            weights_change <= (c_n != c) | (k_n != k);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sauria_tile_pointer_sequencer.md
Name: sauria_tile_pointer_sequencer

Overview:
Parametrised successor of the dataflow controller's DMA pointer generator. Walks a 4-D tile space (x, y, c, k) in one of four programmable loop orders. Emits per-tensor byte offsets for ifmaps, psums and weights, plus per-tensor change flags, over a valid/ready handshake. Sits between the df_controller FSM (start/done) and the DMA request builder (pointer consumer).

Parameters:
CNT_W, 16, width of tile index counters and limits
ADDR_W, 32, width of step inputs and offset outputs

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  pulse; latches config and begins walk when IDLE
x_lim, y_lim, c_lim, k_lim  in  CNT_W each  last index per dimension (inclusive)
ifm_x_step, ifm_y_step, ifm_c_step  in  ADDR_W each  ifmap offset increments
ps_x_step, ps_y_step, ps_k_step  in  ADDR_W each  psum offset increments
w_c_step, w_k_step  in  ADDR_W each  weight offset increments
loop_order  in  2  0: xy→c→k; 1: c→k→xy; 2: k→c→xy; 3: c→xy→k (innermost first)
ptr_valid  out  1  current tile pointer valid
ptr_ready  in  1  consumer accepts pointer
ifmaps_offset, psums_offset, weights_offset  out  ADDR_W each  sum of that tensor's dimension counters
ifmaps_change, psums_change, weights_change  out  1 each  tensor's tile differs from previously accepted tile
last_iter  out  1  current tile is final tile
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after final tile accepted

Behaviour:
- Reset: state IDLE; all indices, per-dimension counters, offsets 0; ptr_valid, done, busy, last_iter 0; change flags 1.
- States: IDLE, RUN, DONE.
- IDLE: start=1 latches all limits, steps, loop_order into shadow registers; clears indices/counters; sets all change flags to 1; next state RUN. No other input is sampled in IDLE.
- RUN: ptr_valid=1. Outputs are combinational from registered state and held stable while ptr_ready=0.
- Handshake: on ptr_valid & ptr_ready, advance per loop order:
  - innermost dimension group always steps;
  - next group steps only when all inner groups wrap.
  - The xy group steps x; y steps when x wraps.
  - Wrap: index == lim → index 0 and counters 0; otherwise index+1 and counter += step.
- Change flags after each handshake:
  - ifmaps_change = any of x, y, c index changed;
  - psums_change = any of x, y, k changed;
  - weights_change = any of c, k changed.
- last_iter = all four indices equal their latched limits.
- Accept with last_iter=1: indices are not advanced; next state DONE.
- DONE: done=1, ptr_valid=0 for exactly one cycle; then IDLE.
- Arithmetic: offsets and counters are ADDR_W modular; overflow wraps silently. Indices are CNT_W.
- Boundaries:
  - All limits 0 → exactly one tile, all change flags 1, then DONE.
  - start during RUN/DONE ignored.
  - Input config changes during RUN have no effect.
  - rst mid-RUN aborts immediately to reset values; no done pulse.
  - ptr_ready held high → one tile per cycle; total handshakes = (x_lim+1)(y_lim+1)(c_lim+1)(k_lim+1).

Optional Feature:
SAURIA_PTRGEN_TILE_COUNT_EN
- Defined: adds output tile_idx [31:0].
  - 0 on reset and on start;
  - increments by 1 on each accepted handshake, wrapping modulo 2^32;
  - holds its value through DONE and IDLE until the next start.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
1. Reset, start with all lims=0, ptr_ready=1 → one tile, offsets 0, all change flags 1, last_iter=1; done pulses 2 cycles after start.
2. x_lim=1, y_lim=1, c_lim=0, k_lim=0, ifm_x_step=4, ifm_y_step=64, loop_order=0 → ifmaps_offset sequence 0, 4, 64, 68; ifmaps_change=1 every tile; weights_change=0 after first tile.
3. c_lim=2, k_lim=1, x_lim=y_lim=0, w_c_step=16, w_k_step=256, loop_order=1 → weights_offset 0, 16, 32, 256, 272, 288; psums_change=1 only on tiles 1 and 4.
4. Same config as 3 with loop_order=2 → weights_offset 0, 256, 16, 272, 32, 288.
5. Same config as 2 with ptr_ready toggling 1010… → outputs stable while ready=0; start pulsed mid-run ignored; total 4 handshakes; exactly one done.
6. rst asserted after 2nd handshake of scenario 2 → next cycle ptr_valid=0, offsets 0, change flags 1, no done; a fresh start replays the full sequence from 0.
